// File: rtl/reg_file_n.sv
// Register file with a background clear sweep; reads are combinational, register 0 reads as zero.
// Optional macro REG_FILE_N_BYPASS_EN forwards busW to reads of the register being written this cycle.
module reg_file_n #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  input  logic [WIDTH-1:0]  busW,
  input  logic              r_type,
  input  logic              reg_wr,
  input  logic              clr,
  output logic [WIDTH-1:0]  busA,
  output logic [WIDTH-1:0]  busB,
  output logic              busy,
  output logic              done,
  output logic              wr_drop
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] rw;
  logic              wr_acc;
  logic [WIDTH-1:0]  regs [DEPTH];

  assign rw     = r_type ? rd : rs2;
  assign wr_acc = reg_wr && (state == IDLE) && (rw != '0);

  always_comb begin
    busA = (rs  == '0) ? '0 : regs[rs];
    busB = (rs2 == '0) ? '0 : regs[rs2];
`ifdef REG_FILE_N_BYPASS_EN
    if (wr_acc && (rs  == rw)) busA = busW;
    if (wr_acc && (rs2 == rw)) busB = busW;
`endif
  end

  // Host writes and sweep clears never coincide: writes are only accepted in IDLE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (wr_acc)           regs[rw]  <= busW;
      if (state == SWEEP)   regs[cnt] <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      done    <= 1'b0;
      wr_drop <= reg_wr && (state == SWEEP) && (rw != '0);
      case (state)
        IDLE: begin
          if (clr) begin
            state <= SWEEP;
            cnt   <= ADDR_W'(1);
            busy  <= 1'b1;
          end
        end
        SWEEP: begin
          // Register 0 is hardwired, so the sweep covers 1..DEPTH-1.
          cnt <= cnt + ADDR_W'(1);
          if (&cnt) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_n.sv
// Directed bench for reg_file_n: reference model of the register contents and sweep,
// compared every cycle, plus literal expectations for the key scenarios.
module tb_reg_file_n;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] rs, rs2, rd;
  logic [WIDTH-1:0]  busW;
  logic              r_type, reg_wr, clr;
  logic [WIDTH-1:0]  busA, busB;
  logic              busy, done, wr_drop;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  reg_file_n #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .rs(rs), .rs2(rs2), .rd(rd), .busW(busW),
    .r_type(r_type), .reg_wr(reg_wr), .clr(clr), .busA(busA), .busB(busB),
    .busy(busy), .done(done), .wr_drop(wr_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: contents array plus number of sweep cycles still to run.
  logic [WIDTH-1:0] m_mem [DEPTH];
  int               m_left = 0;
  logic             m_done = 1'b0;
  logic             m_drop = 1'b0;
  logic [ADDR_W-1:0] m_rw;

  function automatic logic m_accept();
    return reg_wr && (m_left == 0) && ((r_type ? rd : rs2) != '0);
  endfunction

  function automatic logic [WIDTH-1:0] m_read(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] w;
    w = r_type ? rd : rs2;
    if (a == '0) return '0;
`ifdef REG_FILE_N_BYPASS_EN
    if (m_accept() && a == w) return busW;
`endif
    return m_mem[a];
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_left = 0;
      m_done = 1'b0;
      m_drop = 1'b0;
    end else begin
      m_rw   = r_type ? rd : rs2;
      m_drop = reg_wr && (m_left > 0) && (m_rw != '0);
      m_done = 1'b0;
      if (m_left > 0) begin
        m_mem[DEPTH - m_left] = '0;
        m_left--;
        if (m_left == 0) m_done = 1'b1;
      end else begin
        if (reg_wr && m_rw != '0) m_mem[m_rw] = busW;
        if (clr) m_left = DEPTH - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busA",    busA,          m_read(rs));
      chk("cyc_busB",    busB,          m_read(rs2));
      chk("cyc_busy",    32'(busy),     32'(m_left > 0));
      chk("cyc_done",    32'(done),     32'(m_done));
      chk("cyc_wr_drop", 32'(wr_drop),  32'(m_drop));
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    reg_wr = 1'b1; r_type = 1'b1; rd = a; busW = d;
    nxt();
    reg_wr = 1'b0;
  endtask

  task automatic all_zero(input string nm);
    for (int a = 0; a < DEPTH; a++) begin
      rs = ADDR_W'(a); rs2 = ADDR_W'(a);
      #1;
      chk(nm, busA | busB, 32'h0);
    end
  endtask

  int bcnt, dcnt;
  logic [WIDTH-1:0] exp_old;

  initial begin
    reset = 1'b0; rs = '0; rs2 = '0; rd = '0; busW = '0;
    r_type = 1'b0; reg_wr = 1'b0; clr = 1'b0;
    nxt();
    chk_en = 1'b1;
    nxt();
    reset = 1'b1;
    rs = 5'd5; rs2 = 5'd9;
    #1;
    chk("reset_busA", busA, 32'h0);
    chk("reset_busB", busB, 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);

    // Basic write / read on both ports.
    wr(5'd5, 32'hDEADBEEF);
    rs = 5'd5; rs2 = 5'd5;
    #1;
    chk("wr5_busA", busA, 32'hDEADBEEF);
    chk("wr5_busB", busB, 32'hDEADBEEF);

    // Write to register 0 through rs2 addressing.
    reg_wr = 1'b1; r_type = 1'b0; rs2 = 5'd0; rs = 5'd0; busW = 32'h12345678;
    nxt();
    reg_wr = 1'b0;
    #1;
    chk("r0_busA", busA, 32'h0);
    chk("r0_busB", busB, 32'h0);
    chk("r0_wr_drop", 32'(wr_drop), 32'h0);

    // Same-cycle write and read of register 9.
    wr(5'd9, 32'h11111111);
    reg_wr = 1'b1; r_type = 1'b1; rd = 5'd9; busW = 32'hA5A5A5A5; rs = 5'd9;
    #1;
`ifdef REG_FILE_N_BYPASS_EN
    exp_old = 32'hA5A5A5A5;
`else
    exp_old = 32'h11111111;
`endif
    chk("same_cycle_busA", busA, exp_old);
    nxt();
    reg_wr = 1'b0;
    #1;
    chk("after_write_busA", busA, 32'hA5A5A5A5);

    // Fill 1..31 then sweep.
    for (int i = 1; i < DEPTH; i++) wr(ADDR_W'(i), 32'hC0DE0000 | 32'(i));
    rs = 5'd17; rs2 = 5'd31;
    #1;
    chk("fill_r17", busA, 32'hC0DE0011);
    chk("fill_r31", busB, 32'hC0DE001F);
    clr = 1'b1;
    nxt();
    clr = 1'b0;
    bcnt = 0; dcnt = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (busy) bcnt++;
      if (done) dcnt++;
      nxt();
    end
    chk("sweep_busy_cycles", 32'(bcnt), 32'd31);
    chk("sweep_done_pulses", 32'(dcnt), 32'd1);
    all_zero("sweep_cleared");

    // Dropped write and ignored second clr during a sweep.
    wr(5'd7, 32'h00000077);
    clr = 1'b1;
    nxt();
    clr = 1'b0;
    bcnt = 0; dcnt = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 3) begin reg_wr = 1'b1; r_type = 1'b1; rd = 5'd7; busW = 32'h00000BAD; end
      if (c == 4) begin
        reg_wr = 1'b0;
        #1;
        chk("drop_pulse", 32'(wr_drop), 32'h1);
      end
      if (c == 5) begin #1; chk("drop_one_cycle", 32'(wr_drop), 32'h0); end
      if (c == 10) clr = 1'b1;
      if (c == 11) clr = 1'b0;
      #1;
      if (busy) bcnt++;
      if (done) dcnt++;
      nxt();
    end
    chk("reclr_busy_cycles", 32'(bcnt), 32'd31);
    chk("reclr_done_pulses", 32'(dcnt), 32'd1);
    rs = 5'd7;
    #1;
    chk("r7_cleared", busA, 32'h0);

    // Write accepted with clr, then reset aborts the sweep at cycle 10.
    wr(5'd20, 32'h20202020);
    reg_wr = 1'b1; r_type = 1'b1; rd = 5'd3; busW = 32'h00000033; clr = 1'b1;
    nxt();
    reg_wr = 1'b0; clr = 1'b0; rs = 5'd3; rs2 = 5'd20;
    #1;
    chk("wr_with_clr_r3", busA, 32'h00000033);
    chk("sweep_read_r20", busB, 32'h20202020);
    for (int c = 1; c < 10; c++) nxt();
    reset = 1'b0;
    nxt();
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'h0);
    dcnt = 0;
    for (int c = 0; c < 35; c++) begin
      #1;
      if (done) dcnt++;
      nxt();
    end
    chk("abort_no_done", 32'(dcnt), 32'h0);
    all_zero("abort_cleared");

    nxt();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_n.md
REG_FILE_N -- requirements
Module: reg_file_n

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data bits per register.
REQ-002 SHALL have parameter ADDR_W, default 5, address bits; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port rs  input  ADDR_W  read address, port A.
REQ-006 SHALL have port rs2  input  ADDR_W  read address, port B; also write address when r_type=0.
REQ-007 SHALL have port rd  input  ADDR_W  write address when r_type=1.
REQ-008 SHALL have port busW  input  WIDTH  write data.
REQ-009 SHALL have port r_type  input  1  write-address select: 0 selects rs2, 1 selects rd.
REQ-010 SHALL have port reg_wr  input  1  write enable.
REQ-011 SHALL have port clr  input  1  single-cycle request to start a background clear sweep.
REQ-012 SHALL have port busA  output  WIDTH  read data, port A.
REQ-013 SHALL have port busB  output  WIDTH  read data, port B.
REQ-014 SHALL have port busy  output  1  high while the clear sweep runs.
REQ-015 SHALL have port done  output  1  one-cycle pulse on sweep completion.
REQ-016 SHALL have port wr_drop  output  1  one-cycle pulse when a requested write is discarded.

Function
REQ-017 SHALL compute the write address rw = r_type ? rd : rs2.
REQ-018 SHALL return register[rs] on busA and register[rs2] on busB combinationally, with zero-cycle read latency.
REQ-019 SHALL return 0 when register 0 is read; writes to register 0 SHALL be ignored and SHALL NOT assert wr_drop.
REQ-020 SHALL, when reg_wr=1, busy=0 and rw!=0, store busW into register[rw] at the clock edge; data is visible on reads in the next cycle.
REQ-021 SHALL have FSM states IDLE and SWEEP.
REQ-022 In IDLE, clr=1 SHALL move the FSM to SWEEP, load the sweep counter with 1 and set busy=1 from the next cycle.
REQ-023 In SWEEP, each cycle SHALL zero register[counter] and increment the counter; after clearing register DEPTH-1, the FSM SHALL return to IDLE, set busy=0 and pulse done=1 for exactly one cycle.
REQ-024 A sweep SHALL therefore last DEPTH-1 cycles with busy high; for the defaults this is 31 cycles.
REQ-025 A clr received in SWEEP SHALL be ignored and SHALL NOT restart the counter.
REQ-026 A write with reg_wr=1, rw!=0 during SWEEP SHALL be discarded and SHALL pulse wr_drop in the following cycle.
REQ-027 A write in the same cycle as clr is accepted in IDLE SHALL complete; the sweep then zeroes that register.
REQ-028 Reads SHALL remain legal during SWEEP and SHALL return current contents, whether already cleared or not.

Reset
REQ-029 When reset=0 at a clock edge, every register SHALL be set to 0, the FSM set to IDLE, the counter set to 0, and busy, done and wr_drop set to 0.
REQ-030 A reset during SWEEP SHALL abort the sweep with no done pulse; after reset, busA=busB=0 for every address.
REQ-031 Reset SHALL take priority over clr and reg_wr in the same cycle.

Configuration
REQ-032 Macro REG_FILE_N_BYPASS_EN defined: when a write is accepted this cycle and rs (or rs2) equals rw!=0, busA (or busB) SHALL return busW combinationally.
REQ-033 Macro REG_FILE_N_BYPASS_EN undefined: reads SHALL return the stored pre-write value in the write cycle.

Verification
REQ-034 Reset, then write 0xDEADBEEF to reg 5 (r_type=1, rd=5) -> next cycle rs=5 gives busA=0xDEADBEEF; rs2=5 gives busB=0xDEADBEEF.
REQ-035 Write 0x12345678 with r_type=0, rs2=0 -> busA=busB=0 for address 0; wr_drop stays 0.
REQ-036 Fill regs 1..31, pulse clr -> busy high for 31 cycles, done pulses once, then all reads return 0.
REQ-037 Write to reg 7 at sweep cycle 3 -> wr_drop pulses next cycle; reg 7 reads 0 after done; a second clr mid-sweep does not extend busy.
REQ-038 Write 0xA5A5A5A5 to reg 9 with rs=9 in the same cycle -> busA=0xA5A5A5A5 with REG_FILE_N_BYPASS_EN defined, the old value without it.
REQ-039 Assert reset=0 at sweep cycle 10 -> busy=0 next cycle, no done pulse, all registers read 0.
